// File: rtl/lc_companion_integrator.sv
// -----------------------------------------------------------------------------
// lc_companion_integrator
//
// Purpose:
//   Fixed-point history-current engine for the reactive (L/C) companion models
//   of the circuit simulator. One signed history current is held per channel.
//   Each time step every channel is updated serially through one shared signed
//   multiplier:
//      inductor  : I <= I + v*g
//      capacitor : I <= -I + v*g
//   Results are saturated to the W-bit range, never wrapped.
//
// Parameters:
//   W        word width of v, g and history (signed two's complement)
//   FRAC     fractional bits, Q(W-FRAC).FRAC, 0 < FRAC < W
//   N        number of channels (>= 1)
//   CAP_MASK bit k = 1 -> channel k is a capacitor, 0 -> inductor
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   step      in   start one time-step sweep (accepted only when idle)
//   clear     in   zero all histories (honoured only when idle, beats step)
//   v_in      in   N*W per-channel voltage, channel k at [k*W +: W]
//   g_in      in   N*W per-channel coefficient, same packing
//   busy      out  high from step acceptance to the end of the DONE state
//   done      out  one-cycle pulse once all N histories are written
//   hist_out  out  N*W registered history currents, channel k at [k*W +: W]
// -----------------------------------------------------------------------------
module lc_companion_integrator #(
   parameter int            W        = 16,
   parameter int            FRAC     = 8,
   parameter int            N        = 4,
   parameter logic [N-1:0]  CAP_MASK = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step,
   input  logic             clear,
   input  logic [N*W-1:0]   v_in,
   input  logic [N*W-1:0]   g_in,
   output logic             busy,
   output logic             done,
   output logic [N*W-1:0]   hist_out
);

   localparam int             CW      = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0]  LAST_CH = CW'(N - 1);

   // Saturation limits of a W-bit history word.
   localparam logic signed [W-1:0] H_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] H_MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_ACC  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [CW-1:0]          r_ch;
   logic [CW-1:0]          w_ch_next;

   logic signed [W-1:0]    r_v_snap [N];
   logic signed [W-1:0]    r_g_snap [N];
   logic signed [W-1:0]    r_hist   [N];
   logic signed [2*W-1:0]  r_prod;

   logic                   w_accept;
   logic                   w_clear;
   logic [N-1:0]           w_wr_en;

   logic signed [W-1:0]    w_v_sel;
   logic signed [W-1:0]    w_g_sel;
   logic signed [W-1:0]    w_hist_sel;
   logic                   w_is_cap;
   logic signed [2*W-1:0]  w_shift;
   logic                   w_shift_fits;
   logic signed [W+1:0]    w_s;
   logic signed [W-1:0]    w_base;
   logic signed [W+1:0]    w_sum;
   logic                   w_sum_fits;
   logic signed [W-1:0]    w_sat;

   // ------------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------------
   assign w_accept = (r_state == S_IDLE) && step && !clear;
   assign w_clear  = (r_state == S_IDLE) && clear;

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);

   // ------------------------------------------------------------------------
   // FSM: IDLE -> MUL -> ACC -> (MUL | DONE) -> IDLE
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ch    <= '0;
      end else begin
         r_state <= w_state_next;
         r_ch    <= w_ch_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ch_next    = r_ch;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = S_MUL;
               w_ch_next    = '0;
            end
         end
         S_MUL: begin
            w_state_next = S_ACC;
         end
         S_ACC: begin
            if (r_ch == LAST_CH) begin
               w_state_next = S_DONE;
            end else begin
               w_state_next = S_MUL;
               w_ch_next    = r_ch + CW'(1);
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
            w_ch_next    = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Input snapshot: v/g are frozen at acceptance so the sweep is immune to
   // changes on v_in/g_in while busy.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            r_v_snap[k] <= '0;
            r_g_snap[k] <= '0;
         end
      end else if (w_accept) begin
         for (int k = 0; k < N; k++) begin
            r_v_snap[k] <= v_in[k*W +: W];
            r_g_snap[k] <= g_in[k*W +: W];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Shared multiplier (MUL state)
   // ------------------------------------------------------------------------
   assign w_v_sel = r_v_snap[r_ch];
   assign w_g_sel = r_g_snap[r_ch];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod <= '0;
      end else if (r_state == S_MUL) begin
         r_prod <= $signed({{W{w_v_sel[W-1]}}, w_v_sel}) *
                   $signed({{W{w_g_sel[W-1]}}, w_g_sel});
      end
   end

   // ------------------------------------------------------------------------
   // Accumulate (ACC state)
   // ------------------------------------------------------------------------
   // Arithmetic shift: truncation toward -inf.
   assign w_shift = r_prod >>> FRAC;

   // Clamp the shifted product into [-2^W, 2^W-1] and carry it at W+2 bits.
   // Any magnitude beyond that already saturates the final result for every
   // possible base, so the clamp never changes the saturated outcome while it
   // prevents a large product from wrapping.
   assign w_shift_fits = (&w_shift[2*W-1:W]) | ~(|w_shift[2*W-1:W]);

   always_comb begin
      w_s = {w_shift[W], w_shift[W:0]};
      if (!w_shift_fits) begin
         w_s = w_shift[2*W-1] ? {2'b11, {W{1'b0}}} : {2'b00, {W{1'b1}}};
      end
   end

   assign w_hist_sel = r_hist[r_ch];
   assign w_is_cap   = CAP_MASK[r_ch];

   // Capacitor base is the negated history; negating the most negative word
   // saturates to the most positive one.
   always_comb begin
      w_base = w_hist_sel;
      if (w_is_cap) begin
         w_base = (w_hist_sel == H_MIN) ? H_MAX : -w_hist_sel;
      end
   end

   assign w_sum      = {{2{w_base[W-1]}}, w_base} + w_s;
   // Result fits in W bits when the top three bits agree.
   assign w_sum_fits = (&w_sum[W+1:W-1]) | ~(|w_sum[W+1:W-1]);

   always_comb begin
      w_sat = w_sum[W-1:0];
      if (!w_sum_fits) begin
         w_sat = w_sum[W+1] ? H_MIN : H_MAX;
      end
   end

   // ------------------------------------------------------------------------
   // History registers: each word only moves on its own ACC write or clear.
   // ------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_wr
         assign w_wr_en[gi] = (r_state == S_ACC) && (r_ch == CW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            r_hist[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (w_clear) begin
               r_hist[k] <= '0;
            end else if (w_wr_en[k]) begin
               r_hist[k] <= w_sat;
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_out
         assign hist_out[gi*W +: W] = r_hist[gi];
      end
   endgenerate

endmodule

// File: tb/tb_lc_companion_integrator.sv
// -----------------------------------------------------------------------------
// tb_lc_companion_integrator
//
// Directed test of lc_companion_integrator at W=16, FRAC=8, N=4,
// CAP_MASK=4'b0010 (channel 1 capacitor, others inductors). Expected values
// are hand-computed Q8.8 constants.
// -----------------------------------------------------------------------------
module tb_lc_companion_integrator;

   localparam int         W   = 16;
   localparam int         N   = 4;
   localparam logic [3:0] CAP = 4'b0010;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic            step  = 1'b0;
   logic            clear = 1'b0;
   logic [N*W-1:0]  v_in  = '0;
   logic [N*W-1:0]  g_in  = '0;
   logic            busy;
   logic            done;
   logic [N*W-1:0]  hist_out;

   int n_total = 0;
   int n_bad   = 0;

   lc_companion_integrator #(
      .W        (W),
      .FRAC     (8),
      .N        (N),
      .CAP_MASK (CAP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .step     (step),
      .clear    (clear),
      .v_in     (v_in),
      .g_in     (g_in),
      .busy     (busy),
      .done     (done),
      .hist_out (hist_out)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int k, input logic [15:0] v, input logic [15:0] g);
      v_in[k*W +: W] = v;
      g_in[k*W +: W] = g;
   endtask

   task automatic check_hist(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
      check_val({tag, "_h0"}, hist_out[0*W +: W], e0);
      check_val({tag, "_h1"}, hist_out[1*W +: W], e1);
      check_val({tag, "_h2"}, hist_out[2*W +: W], e2);
      check_val({tag, "_h3"}, hist_out[3*W +: W], e3);
   endtask

   // One full sweep; done must appear in the cycle following edge t0+2N.
   task automatic run_step(input string tag);
      int cnt;
      step = 1'b1;
      tick();
      step = 1'b0;
      cnt  = 0;
      while (!done && cnt < 20) begin
         tick();
         cnt++;
      end
      check_val({tag, "_done"}, done, 1'b1);
      check_val({tag, "_lat"}, cnt, 8);
      tick();
      check_val({tag, "_idle"}, busy, 1'b0);
      $display("step %s: hist_out=%h cycles_to_done=%0d", tag, hist_out, cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] exp_new [4];
      int          done_cnt;

      // ---------------- reset state ----------------
      rst_n = 1'b0;
      repeat (3) tick();
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_done", done, 1'b0);
      check_val("rst_hist", hist_out, 64'h0);
      rst_n = 1'b1;
      tick();

      // ---------------- step A: load initial histories ----------------
      set_ch(0, 16'h0200, 16'h0080);   // 2.0*0.5 -> 1.0
      set_ch(1, 16'h0100, 16'h0100);   // cap from 0 -> 1.0
      set_ch(2, 16'h7F00, 16'h0100);   // 127.0
      set_ch(3, 16'h8000, 16'h0100);   // -128.0
      run_step("A");
      check_hist("A", 16'h0100, 16'h0100, 16'h7F00, 16'h8000);

      // ---------------- step B: second step, cap and saturation ----------------
      set_ch(0, 16'h0200, 16'h0080);   // 1.0 + 1.0
      set_ch(1, 16'h0100, 16'h0300);   // -1.0 + 3.0
      set_ch(2, 16'h0400, 16'h0100);   // 127 + 4 -> sat
      set_ch(3, 16'hFC00, 16'h0100);   // -128 - 4 -> sat
      run_step("B");
      check_hist("B", 16'h0200, 16'h0200, 16'h7FFF, 16'h8000);

      // ---------------- clear + step together in IDLE ----------------
      clear = 1'b1;
      step  = 1'b1;
      tick();
      clear = 1'b0;
      step  = 1'b0;
      check_val("clr_hist", hist_out, 64'h0);
      check_val("clr_busy", busy, 1'b0);
      tick();
      check_val("clr_busy2", busy, 1'b0);
      check_val("clr_done2", done, 1'b0);
      $display("clear: hist_out=%h busy=%0b", hist_out, busy);

      // ---------------- step C: per-cycle timing, ignored step/clear ----------------
      set_ch(0, 16'hFE00, 16'h0080);   // -2.0*0.5 -> -1.0
      set_ch(1, 16'h8000, 16'h8000);   // huge product, cap -> sat high
      set_ch(2, 16'h0180, 16'hFF00);   // 1.5*-1.0 -> -1.5
      set_ch(3, 16'h0001, 16'hFFFF);   // -1 LSB^2 floors to -1 LSB
      exp_new[0] = 16'hFF00;
      exp_new[1] = 16'h7FFF;
      exp_new[2] = 16'hFE80;
      exp_new[3] = 16'hFFFF;
      done_cnt   = 0;
      step = 1'b1;
      tick();                          // acceptance edge t0
      step = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         check_val($sformatf("C_busy_t%0d", k), busy, (k <= 8) ? 1'b1 : 1'b0);
         check_val($sformatf("C_done_t%0d", k), done, (k == 8) ? 1'b1 : 1'b0);
         if (done) done_cnt++;
         for (int j = 0; j < 4; j++) begin
            check_val($sformatf("C_h%0d_t%0d", j, k), hist_out[j*W +: W],
                      (k >= 2*j + 2) ? exp_new[j] : 16'h0000);
         end
         step  = (k == 2);             // sampled at edge t0+3
         clear = (k == 4);             // sampled at edge t0+5
         if (k == 1) begin
            v_in = '1;                 // must not affect the running sweep
            g_in = '1;
         end
         tick();
      end
      step  = 1'b0;
      clear = 1'b0;
      check_val("C_done_pulses", done_cnt, 1);
      $display("step C: hist_out=%h done_pulses=%0d", hist_out, done_cnt);

      // ---------------- steps D/E: negating the most negative history ----------------
      v_in = '0;
      g_in = '0;
      set_ch(1, 16'h0001, 16'hFFFF);   // -(0x7FFF) - 1 LSB -> 0x8000
      run_step("D");
      check_hist("D", 16'hFF00, 16'h8000, 16'hFE80, 16'hFFFF);
      v_in = '0;
      g_in = '0;
      run_step("E");                   // -(-32768) saturates
      check_hist("E", 16'hFF00, 16'h7FFF, 16'hFE80, 16'hFFFF);

      // ---------------- reset mid-sweep ----------------
      v_in = '0;
      g_in = '0;
      set_ch(0, 16'h0400, 16'h0080);   // -1.0 + 2.0 -> 1.0
      step = 1'b1;
      tick();                          // t0
      step = 1'b0;
      repeat (4) tick();               // just after t0+4
      check_val("R_pre_busy", busy, 1'b1);
      check_val("R_pre_h0", hist_out[0 +: W], 16'h0100);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("R_hist", hist_out, 64'h0);
      check_val("R_busy", busy, 1'b0);
      check_val("R_done", done, 1'b0);
      $display("reset mid-sweep: hist_out=%h busy=%0b done=%0b", hist_out, busy, done);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check_val("R_post_busy", busy, 1'b0);

      // ---------------- fresh step after reset ----------------
      v_in = '0;
      g_in = '0;
      set_ch(0, 16'h0200, 16'h0080);
      run_step("G");
      check_hist("G", 16'h0100, 16'h0000, 16'h0000, 16'h0000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
